var_shift_engine: RTL and testbench
===================================

# var_shift_engine

Parametrised multi-cycle variable shifter/rotator that succeeds the single-cycle 32-bit variable shift register. It holds a WIDTH-bit data register and, on a start request, shifts it by 0..WIDTH-1 positions in chunks of at most STEP bits per clock, one chunk per clock, with a busy/done handshake. It sits between a register-file style producer and any consumer that needs a shifted word.

## Interface
- WIDTH, 32: data width; power of 2, ≥ 8.
- STEP, 8: maximum bits shifted per clock; power of 2, 1 ≤ STEP ≤ WIDTH.
- AW, $clog2(WIDTH): width of amount (derived, not overridden).

- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- en  in  1  stall control; 0 freezes all state, including done.
- load  in  1  parallel load request.
- load_data  in  WIDTH  value loaded into q.
- start  in  1  shift request; accepted only while ready=1.
- dir  in  1  0 = right, 1 = left; captured at start.
- mode  in  2  00 logical/fill, 01 arithmetic, 10 rotate, 11 logical/fill; captured at start.
- amount  in  AW  total shift distance n; captured at start.
- fill_in  in  WIDTH  fill source for vacated bits; captured at start.
- q  out  WIDTH  data register.
- ready  out  1  ~busy (combinational).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse (while en=1) marking final q.

## Operation
- States: IDLE, SHIFT. clr=0 → IDLE, q=0, busy=0, done=0, internal fill/count regs 0, regardless of clk.
- IDLE with en=1:
  - load=1: q ← load_data. load has priority, so a simultaneous start is dropped.
  - start=1 with load=0: capture dir, mode, amount, fill_in into a fill register F. Set remaining count r=n. Go to SHIFT. busy=1.
- SHIFT with en=1, each clock:
  - Shift by s = min(r, STEP); r ← r−s.
  - When r reaches 0, or if n=0 (s=0, single pass), go to IDLE with busy=0 and done=1 for that one cycle.
  - load and start are ignored while busy.
- Result must equal a single shift by n:
  - logical right (mode 00/11, dir 0): q = {fill_in[n−1:0], q[W−1:n]}.
  - logical left: q = {q[W−1−n:0], fill_in[W−1:W−n]}.
  - Implement as a joint shift of {F,q} (right) or {q,F} (left) by s per step, so fill bits are consumed low-first (right) or high-first (left).
  - arithmetic (01): right fills with q[W−1] captured at start, and fill_in is ignored. Left fills with zeros.
  - rotate (10): bits leaving one end enter the other; fill_in is ignored.
- n=0: q unchanged after one SHIFT cycle.
- en=0 in any state: no change to q, state, r, F, busy or done.

## Timing
- start accepted at edge 0. SHIFT updates q at edges 1..k, where k = max(1, ceil(n/STEP)).
- done and busy=0 take effect at edge k together with the final q. The next start can be accepted at edge k+1.
- With en=0 cycles inserted, latency extends by exactly the number of stalled edges.
- done is high for one enabled cycle, then clears on the next enabled edge.
- ready = ~busy with no registered delay.
- clr mid-SHIFT aborts immediately. The partial result is discarded (q=0) and there is no done pulse.

## Configuration
- VAR_SHIFT_ROTATE_EN defined: rotate mode (10) is implemented as described.
- VAR_SHIFT_ROTATE_EN undefined: the rotate logic is compiled out, and mode 10 behaves as logical/fill (same as 00).

## Test plan
- WIDTH=32, STEP=8. load 0x8000_0001, then start dir=0 mode=00 n=4 fill_in=0x0000_000F → done at edge 1, q=0xF800_0000.
- load 0x8000_0000, start dir=0 mode=01 n=20 → 3 SHIFT cycles (8,8,4), done at edge 3, q=0xFFFF_F800.
- load 0x1234_5678, start dir=1 mode=10 n=12 → done at edge 2, q=0x4567_8123. Without VAR_SHIFT_ROTATE_EN and fill_in=0 → q=0x4567_8000.
- load 0x0000_00FF, start dir=1 mode=00 n=31 fill_in=0 → done at edge 4, q=0x8000_0000. A start pulse at edge 2 is ignored, and ready=0 throughout.
- start n=0 → done at edge 1, q unchanged. Repeat with en=0 for 2 cycles mid-operation on an n=20 shift → done at edge 5, q correct.
- Drop clr during SHIFT of an n=24 operation → q=0, busy=0, done=0 without waiting for clk. After release, the block sits in IDLE with ready=1.

Source files
------------

// File: rtl/var_shift_engine.sv
`default_nettype none
// var_shift_engine: multi-cycle variable shifter/rotator, at most STEP bits per clock, with a busy/done handshake.
// Optional VAR_SHIFT_ROTATE_EN enables rotate mode (10); without it, mode 10 behaves as logical/fill.
module var_shift_engine #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    amount,
  input  logic [WIDTH-1:0] fill_in,
  output logic [WIDTH-1:0] q,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [AW:0] STEP_W  = (AW+1)'(STEP);
  localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] fill_q, fill_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic [AW:0]        step_amt;
  logic               last_step;
  logic [2*WIDTH-1:0] cat_r, cat_l;
  logic [WIDTH-1:0]   step_data, step_fill;
  logic [WIDTH-1:0]   start_fill;
  logic               rot_start;

  // Chunk size for this clock: min(remaining, STEP); n=0 yields a single zero-length pass.
  assign step_amt  = ({1'b0, rem_q} > STEP_W) ? STEP_W : {1'b0, rem_q};
  assign last_step = ({1'b0, rem_q} <= STEP_W);

  // Fill bits travel with the data so they are consumed low-first (right) or high-first (left).
  assign cat_r = {fill_q, data_q} >> step_amt;
  assign cat_l = {data_q, fill_q} << step_amt;

`ifdef VAR_SHIFT_ROTATE_EN
  logic             rot_q, rot_d;
  logic [WIDTH-1:0] rot_right, rot_left;

  assign rot_start = (mode == 2'b10);
  assign rot_right = (data_q >> step_amt) | (data_q << (WIDTH_W - step_amt));
  assign rot_left  = (data_q << step_amt) | (data_q >> (WIDTH_W - step_amt));
`else
  assign rot_start = 1'b0;
`endif

  always_comb begin
    if (dir_q) begin
      step_data = cat_l[2*WIDTH-1:WIDTH];
      step_fill = cat_l[WIDTH-1:0];
    end else begin
      step_data = cat_r[WIDTH-1:0];
      step_fill = cat_r[2*WIDTH-1:WIDTH];
    end
`ifdef VAR_SHIFT_ROTATE_EN
    if (rot_q) begin
      step_data = dir_q ? rot_left : rot_right;
    end
`endif
  end

  // Arithmetic right replicates the sign captured at start; arithmetic left and rotate fill zeros.
  always_comb begin
    if (rot_start || ((mode == 2'b01) && dir)) begin
      start_fill = '0;
    end else if (mode == 2'b01) begin
      start_fill = {WIDTH{data_q[WIDTH-1]}};
    end else begin
      start_fill = fill_in;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = done_q;
`ifdef VAR_SHIFT_ROTATE_EN
    rot_d   = rot_q;
`endif
    if (en) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            data_d = load_data;
          end else if (start) begin
            state_d = S_SHIFT;
            dir_d   = dir;
            fill_d  = start_fill;
            rem_d   = amount;
`ifdef VAR_SHIFT_ROTATE_EN
            rot_d   = rot_start;
`endif
          end
        end
        S_SHIFT: begin
          data_d = step_data;
          fill_d = step_fill;
          rem_d  = rem_q - step_amt[AW-1:0];
          if (last_step) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef VAR_SHIFT_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
`ifdef VAR_SHIFT_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign q     = data_q;
  assign busy  = (state_q == S_SHIFT);
  assign ready = ~busy;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_var_shift_engine.sv
`default_nettype none
// tb_var_shift_engine: scoreboard bench for var_shift_engine (WIDTH=32, STEP=8) with a bit-serial reference model.
module tb_var_shift_engine;
  localparam int W    = 32;
  localparam int STEP = 8;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          clr, en, load, start, dir;
  logic [1:0]    mode;
  logic [AW-1:0] amount;
  logic [W-1:0]  load_data, fill_in, q;
  logic          ready, busy, done;

  always #5 clk = ~clk;

  var_shift_engine #(.WIDTH(W), .STEP(STEP)) dut (
    .clk(clk), .clr(clr), .en(en), .load(load), .load_data(load_data),
    .start(start), .dir(dir), .mode(mode), .amount(amount), .fill_in(fill_in),
    .q(q), .ready(ready), .busy(busy), .done(done)
  );

  typedef struct {
    logic [W-1:0] q;
    int           k;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           errors = 0;
  int           checks = 0;
  int           k_cnt  = 0;
  bit           armed  = 1'b0;
  logic [W-1:0] model_q;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One bit per iteration, straight from the shift rules.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input logic d,
                                             input logic [1:0] m, input int n, input logic [W-1:0] f);
    logic [W-1:0] r;
    logic         msb;
    bit           rot;
    r   = v;
    msb = v[W-1];
`ifdef VAR_SHIFT_ROTATE_EN
    rot = (m == 2'b10);
`else
    rot = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      if (rot)              r = d ? {r[W-2:0], r[W-1]} : {r[0], r[W-1:1]};
      else if (m == 2'b01)  r = d ? {r[W-2:0], 1'b0}   : {msb, r[W-1:1]};
      else                  r = d ? {r[W-2:0], f[W-1-i]} : {f[i], r[W-1:1]};
    end
    return r;
  endfunction

  // Monitor: counts enabled busy edges and pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    if (!clr) begin
      k_cnt = 0;
      armed = 1'b0;
    end else begin
      if (armed) k_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: done=1 got with no operation pending, expected done=0");
        end else begin
          mon_e = sb.pop_front();
          check("result_q", q, mon_e.q);
          check("latency_k", k_cnt, mon_e.k);
        end
        k_cnt = 0;
      end
      armed = busy && en;
    end
  end

  task automatic do_load(input logic [W-1:0] v, input bit with_start);
    @(posedge clk); #1;
    load = 1'b1; load_data = v; start = with_start;
    dir = 1'b0; mode = 2'b00; amount = 5'd3; fill_in = '1;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    check("load_q", q, v);
    check("load_busy", busy, 1'b0);
    model_q = v;
  endtask

  task automatic do_op(input logic d, input logic [1:0] m, input int n, input logic [W-1:0] f,
                       input logic [W-1:0] expq, input int stall_at, input int nstall, input bit poke);
    int k, lat, stalled;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; dir = d; mode = m; amount = AW'(n); fill_in = f;
    k = (n == 0) ? 1 : (n + STEP - 1) / STEP;
    sb.push_back('{expq, k});
    model_q = expq;
    @(posedge clk); #1;
    start = 1'b0;
    dir = $urandom_range(0, 1); mode = 2'($urandom); amount = AW'($urandom); fill_in = $urandom;
    check("start_busy", busy, 1'b1);
    lat = 0; stalled = 0; seen = 1'b0;
    while (!seen && lat < 64) begin
      if (lat >= stall_at && stalled < nstall) begin
        en = 1'b0;
        stalled++;
      end else begin
        en = 1'b1;
      end
      if (poke && lat == 1) begin
        start = 1'b1; load = 1'b1; load_data = $urandom;
      end else begin
        start = 1'b0; load = 1'b0;
      end
      @(posedge clk); lat++; #1;
      if (done) seen = 1'b1;
      else if (poke) check("ready_while_busy", ready, 1'b0);
    end
    en = 1'b1; start = 1'b0; load = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 64 edges, expected done at edge %0d", k + nstall);
    end
    check("latency_total", lat, k + nstall);
    check("ready_after_done", ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] v, f, e;
    logic         d;
    logic [1:0]   m;
    int           n, k, st;

    clr = 1'b0; en = 1'b1; load = 1'b0; start = 1'b0; dir = 1'b0;
    mode = 2'b00; amount = '0; load_data = '0; fill_in = '0;
    #2;
    check("reset_q", q, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ready", ready, 1'b1);
    @(negedge clk); @(negedge clk);
    clr = 1'b1;

    do_load(32'h8000_0001, 1'b0);
    do_op(1'b0, 2'b00, 4, 32'h0000_000F, 32'hF800_0000, 99, 0, 1'b0);

    do_load(32'h8000_0000, 1'b0);
    do_op(1'b0, 2'b01, 20, 32'hFFFF_FFFF, 32'hFFFF_F800, 99, 0, 1'b0);

    do_load(32'h1234_5678, 1'b0);
`ifdef VAR_SHIFT_ROTATE_EN
    do_op(1'b1, 2'b10, 12, 32'h0, 32'h4567_8123, 99, 0, 1'b0);
`else
    do_op(1'b1, 2'b10, 12, 32'h0, 32'h4567_8000, 99, 0, 1'b0);
`endif

    do_load(32'h0000_00FF, 1'b0);
    do_op(1'b1, 2'b00, 31, 32'h0, 32'h8000_0000, 99, 0, 1'b1);

    do_load(32'hDEAD_BEEF, 1'b0);
    do_op(1'b0, 2'b00, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 99, 0, 1'b0);

    do_load(32'h8000_0000, 1'b0);
    do_op(1'b0, 2'b01, 20, 32'h0, 32'hFFFF_F800, 1, 2, 1'b0);

    do_load(32'hA5A5_0F0F, 1'b1);

    @(posedge clk); #1;
    en = 1'b0; load = 1'b1; load_data = 32'h1111_1111;
    @(posedge clk); #1;
    en = 1'b1; load = 1'b0;
    check("load_stalled", q, 32'hA5A5_0F0F);

    for (int i = 0; i < 40; i++) begin
      v = $urandom; f = $urandom; d = $urandom_range(0, 1);
      m = 2'($urandom); n = $urandom_range(0, W - 1);
      k = (n == 0) ? 1 : (n + STEP - 1) / STEP;
      st = $urandom_range(0, 3);
      do_load(v, 1'b0);
      e = ref_shift(v, d, m, n, f);
      if (st == 0) do_op(d, m, n, f, e, $urandom_range(0, k - 1), $urandom_range(1, 3), 1'b0);
      else         do_op(d, m, n, f, e, 99, 0, 1'b0);
    end

    do_load(32'h0F0F_0F0F, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; dir = 1'b0; mode = 2'b00; amount = 5'd24; fill_in = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    clr = 1'b0;
    #1;
    check("abort_q", q, 32'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    #2;
    clr = 1'b1;
    model_q = '0;
    @(posedge clk); #1;
    check("post_abort_ready", ready, 1'b1);
    check("post_abort_q", q, model_q);
    repeat (4) @(posedge clk);
    #1;
    check("post_abort_busy", busy, 1'b0);
    check("scoreboard_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
